// File: rtl/cory_edge_detect.sv
// cory_edge_detect: N-channel edge detector. Each channel runs its own
// synchroniser -> debounce filter -> edge qualify -> one-shot pulse and sticky flag.
// Channels share only clk, reset and the global OR of the flags.
module cory_edge_detect #(
    parameter int N    = 8,    // number of channels (1..32)
    parameter int SYNC = 2,    // synchroniser stages (0..3); 0 = input already in clk domain
    parameter int DEB  = 0,    // level changes after DEB+1 consecutive disagreeing samples
    parameter bit INIT = 1'b0  // reset value of synchroniser stages and filtered level
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   i_a,
    input  logic [2*N-1:0] i_mode,
    input  logic [N-1:0]   i_clr,
    output logic [N-1:0]   o_z,
    output logic [N-1:0]   o_lvl,
    output logic [N-1:0]   o_flag,
    output logic           o_any
);

    // Debounce counter only ever counts up to DEB, so clog2(DEB+1) bits suffice.
    localparam int            CW      = (DEB > 0) ? $clog2(DEB + 1) : 1;
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB);

    // Synchronised channel inputs feeding the debounce filters.
    logic [N-1:0] w_s;

    generate
        if (SYNC == 0) begin : g_nosync
            assign w_s = i_a;
        end else begin : g_sync
            // Stage [0] is nearest the pins, stage [SYNC-1] feeds the filter.
            logic [SYNC-1:0][N-1:0] r_sync;
            logic [SYNC-1:0][N-1:0] w_sync_next;

            if (SYNC == 1) begin : g_one
                assign w_sync_next = i_a;
            end else begin : g_multi
                assign w_sync_next = {r_sync[SYNC-2:0], i_a};
            end

            // Shift the raw inputs one stage along the synchroniser chain.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sync <= {SYNC{ {N{INIT}} }};
                end else begin
                    r_sync <= w_sync_next;
                end
            end

            assign w_s = r_sync[SYNC-1];
        end
    endgenerate

    generate
        for (genvar k = 0; k < N; k++) begin : g_ch
            logic [CW-1:0] r_cnt;
            logic          r_lvl;
            logic          r_z;
            logic          r_flag;
            logic          w_upd;
            logic          w_z_next;

            // Update event: input has disagreed with the level for DEB+1 samples;
            // qualify the new level against the channel mode sampled right now.
            always_comb begin
                w_upd    = 1'b0;
                w_z_next = 1'b0;
                if ((w_s[k] != r_lvl) && (r_cnt == DEB_MAX)) begin
                    w_upd    = 1'b1;
                    w_z_next = w_s[k] ? i_mode[2*k] : i_mode[2*k+1];
                end
            end

            // Filter level/counter, one-shot pulse and sticky flag (set wins over clear).
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt  <= '0;
                    r_lvl  <= INIT;
                    r_z    <= 1'b0;
                    r_flag <= 1'b0;
                end else begin
                    if (w_s[k] == r_lvl) begin
                        r_cnt <= '0;
                    end else if (w_upd) begin
                        r_lvl <= w_s[k];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    r_z    <= w_z_next;
                    r_flag <= (r_flag & ~i_clr[k]) | w_z_next;
                end
            end

            assign o_z[k]    = r_z;
            assign o_lvl[k]  = r_lvl;
            assign o_flag[k] = r_flag;
        end
    endgenerate

    assign o_any = |o_flag;

endmodule

// File: tb/tb_cory_edge_detect.sv
// Bench for cory_edge_detect: three configurations share one stimulus stream,
// each tracked by a queue-based reference model, plus directed literal checks.
module tb_cory_edge_detect;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic [7:0]  a      = '0;
    logic [15:0] mode   = 16'hFFE5;   // ch0=01 ch1=01 ch2=10 ch3=11 ch4..7=11
    logic [7:0]  clr    = '0;
    logic        chk_en = 1'b0;
    int          checks   = 0;
    int          failures = 0;
    int          pc [3][8];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Instance 0: SYNC=2 DEB=0; instance 1: SYNC=2 DEB=4; instance 2: SYNC=0 DEB=0.
    for (genvar g = 0; g < 3; g++) begin : g_i
        localparam int GS = (g == 2) ? 0 : 2;
        localparam int GD = (g == 1) ? 4 : 0;

        logic [7:0] z, lvl, flag;
        logic       any;
        logic [7:0] m_z, m_lvl, m_flag, m_s, m_zn;
        logic       m_alldiff;
        logic [7:0] m_dly [$];
        logic [7:0] m_win [$];

        cory_edge_detect #(.N(8), .SYNC(GS), .DEB(GD), .INIT(1'b0)) u_dut (
            .clk    (clk),
            .reset  (rst),
            .i_a    (a),
            .i_mode (mode),
            .i_clr  (clr),
            .o_z    (z),
            .o_lvl  (lvl),
            .o_flag (flag),
            .o_any  (any)
        );

        // Reference: input is seen GS edges late; level flips when the last GD+1
        // seen samples all disagree with it; mode decides whether that is a pulse.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m_z = '0;
                m_lvl = '0;
                m_flag = '0;
                m_dly.delete();
                m_win.delete();
                for (int i = 0; i < GS; i++) m_dly.push_back(8'h00);
                for (int i = 0; i <= GD; i++) m_win.push_back(8'h00);
            end else begin
                if (GS == 0) begin
                    m_s = a;
                end else begin
                    m_dly.push_back(a);
                    m_s = m_dly.pop_front();
                end
                m_win.push_back(m_s);
                void'(m_win.pop_front());
                m_zn = '0;
                for (int k = 0; k < 8; k++) begin
                    m_alldiff = 1'b1;
                    foreach (m_win[j]) if (m_win[j][k] == m_lvl[k]) m_alldiff = 1'b0;
                    if (m_alldiff) begin
                        m_lvl[k] = m_s[k];
                        m_zn[k]  = m_s[k] ? mode[2*k] : mode[2*k+1];
                    end
                end
                m_flag = (m_flag & ~clr) | m_zn;
                m_z    = m_zn;
            end
        end
    end

    // Every-cycle comparison of all three instances against their models.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("c0_z",    g_i[0].z,    g_i[0].m_z);
            chk("c0_lvl",  g_i[0].lvl,  g_i[0].m_lvl);
            chk("c0_flag", g_i[0].flag, g_i[0].m_flag);
            chk("c0_any",  g_i[0].any,  |g_i[0].m_flag);
            chk("c1_z",    g_i[1].z,    g_i[1].m_z);
            chk("c1_lvl",  g_i[1].lvl,  g_i[1].m_lvl);
            chk("c1_flag", g_i[1].flag, g_i[1].m_flag);
            chk("c1_any",  g_i[1].any,  |g_i[1].m_flag);
            chk("c2_z",    g_i[2].z,    g_i[2].m_z);
            chk("c2_lvl",  g_i[2].lvl,  g_i[2].m_lvl);
            chk("c2_flag", g_i[2].flag, g_i[2].m_flag);
            chk("c2_any",  g_i[2].any,  |g_i[2].m_flag);
        end
    end

    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            pc[0][k] += int'(g_i[0].z[k]);
            pc[1][k] += int'(g_i[1].z[k]);
            pc[2][k] += int'(g_i[2].z[k]);
        end
    endtask

    task automatic clear_pc();
        for (int g = 0; g < 3; g++)
            for (int k = 0; k < 8; k++) pc[g][k] = 0;
    endtask

    // Bit i of each result is o_z[ch] seen after the (i+1)-th edge from now.
    task automatic rec(input int ch, input int n,
                       output logic [15:0] r0, output logic [15:0] r1, output logic [15:0] r2);
        r0 = '0; r1 = '0; r2 = '0;
        for (int i = 0; i < n; i++) begin
            step();
            r0[i] = g_i[0].z[ch];
            r1[i] = g_i[1].z[ch];
            r2[i] = g_i[2].z[ch];
        end
    endtask

    logic [15:0] r0, r1, r2;
    logic        seen;
    logic [7:0]  rz, rl;

    initial begin
        clear_pc();
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) step();
        chk("rst_z",    g_i[0].z,    8'h00);
        chk("rst_lvl",  g_i[0].lvl,  8'h00);
        chk("rst_flag", g_i[0].flag, 8'h00);
        chk("rst_any",  g_i[0].any,  1'b0);
        rst = 1'b0;
        repeat (4) step();

        // Basic rising edge on channel 0.
        a[0] = 1'b1;
        rec(0, 8, r0, r1, r2);
        chk("rise_c0", r0, 16'h0004);
        chk("rise_c1", r1, 16'h0040);
        chk("rise_c2", r2, 16'h0001);
        chk("rise_lvl",  g_i[0].lvl[0],  1'b1);
        chk("rise_flag", g_i[0].flag[0], 1'b1);
        chk("rise_any",  g_i[0].any,     1'b1);

        // Modes 00/01/10/11 on channels 0..3, 20-cycle half-period square wave.
        mode = 16'hFFE4;
        clear_pc();
        a[3:0] = 4'hF; repeat (20) step();
        a[3:0] = 4'h0; repeat (20) step();
        a[3:0] = 4'hF; repeat (20) step();
        a[3:0] = 4'h0; repeat (20) step();
        chk("mode_off_c0",  pc[0][0], 0);
        chk("mode_rise_c0", pc[0][1], 2);
        chk("mode_fall_c0", pc[0][2], 2);
        chk("mode_both_c0", pc[0][3], 4);
        chk("mode_off_c1",  pc[1][0], 0);
        chk("mode_both_c1", pc[1][3], 4);
        chk("mode_lvl_c0",  g_i[0].lvl[3:0], 4'h0);

        // Debounce: glitches of 1..4 cycles must not reach the DEB=4 filter.
        clear_pc();
        seen = 1'b0;
        for (int len = 1; len <= 4; len++) begin
            a[4] = 1'b1;
            repeat (len) begin step(); seen |= g_i[1].lvl[4]; end
            a[4] = 1'b0;
            repeat (12) begin step(); seen |= g_i[1].lvl[4]; end
        end
        chk("deb_glitch_pulses", pc[1][4], 0);
        chk("deb_glitch_lvl",    seen, 1'b0);
        chk("deb_glitch_c0",     pc[0][4], 8);
        a[4] = 1'b1;
        rec(4, 10, r0, r1, r2);
        chk("deb_hold_c1", r1, 16'h0040);
        chk("deb_hold_lvl", g_i[1].lvl[4], 1'b1);

        // Flag clear colliding with a pulse on channel 2 (falling mode).
        a[2] = 1'b1;
        repeat (10) step();
        clr = 8'hFF; step(); clr = 8'h00;
        a[2] = 1'b0;
        step(); step();
        clr[2] = 1'b1;
        step();
        chk("clr_same_z",    g_i[0].z[2],    1'b1);
        chk("clr_same_flag", g_i[0].flag[2], 1'b1);
        step();
        chk("clr_next_flag", g_i[0].flag[2], 1'b0);
        chk("clr_next_any",  g_i[0].any,     1'b0);
        clr = 8'h00;

        // Reset while the DEB=4 filter is at count 3 on channel 5.
        a[5] = 1'b1;
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_z0",    g_i[0].z,    8'h00);
        chk("mid_rst_flag0", g_i[0].flag, 8'h00);
        chk("mid_rst_lvl0",  g_i[0].lvl,  8'h00);
        chk("mid_rst_z1",    g_i[1].z,    8'h00);
        chk("mid_rst_lvl1",  g_i[1].lvl,  8'h00);
        chk("mid_rst_any2",  g_i[2].any,  1'b0);
        step(); step();
        rst = 1'b0;
        rec(5, 8, r0, r1, r2);
        chk("post_rst_c0", r0, 16'h0004);
        chk("post_rst_c1", r1, 16'h0040);
        chk("post_rst_c2", r2, 16'h0001);

        // SYNC=0, DEB=0, mode 11: channel 6 toggling every cycle.
        rz = '0; rl = '0;
        for (int i = 0; i < 8; i++) begin
            a[6] = ~a[6];
            step();
            rz[i] = g_i[2].z[6];
            rl[i] = g_i[2].lvl[6];
        end
        chk("tog_z",   rz, 8'hFF);
        chk("tog_lvl", rl, 8'h55);

        repeat (5) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cory_edge_detect.md
# cory_edge_detect

Multi-channel, parametrised edge detector producing one-shot pulses with input synchronisation, debounce filtering, per-channel edge mode and sticky event flags. It is the general-purpose successor to the single-channel rising-edge one-shot. It sits between raw or asynchronous status/strobe inputs and control logic or interrupt aggregation. Each of the N channels is independent apart from a shared clock, shared reset and one global OR of the flags.

## Interface
- N, 8, number of channels (1..32).
- SYNC, 2, synchroniser register stages per channel (0..3). 0 means the input is already in the clk domain and is used directly.
- DEB, 0, debounce length. The synchronised input must differ from the filtered level for DEB+1 consecutive samples before the level changes. 0 means no filtering beyond one register.
- INIT, 0, reset value of every synchroniser stage and filtered level (1 bit, applied to all channels).
- clk  input  1  clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_a  input  N  raw channel inputs.
- i_mode  input  2N  per-channel mode: bits [2k+1:2k] for channel k. 00 = off, 01 = rising, 10 = falling, 11 = both.
- i_clr  input  N  per-channel sticky-flag clear, level-sensitive.
- o_z  output  N  one-cycle event pulse per channel.
- o_lvl  output  N  filtered (debounced) level per channel.
- o_flag  output  N  sticky event flag per channel.
- o_any  output  1  OR of all o_flag bits (combinational).

## Operation
- Per-channel pipeline: synchroniser chain, then debounce filter, then edge qualify, then pulse and flag.
- **Synchroniser:** s is the output of the SYNC-stage register chain; s = i_a when SYNC = 0.
- **Debounce:**
  - Counter cnt has width clog2(DEB+1), minimum 1 bit.
  - If s == o_lvl: cnt <= 0.
  - Else if cnt == DEB: o_lvl <= s and cnt <= 0. This is the "update" event.
  - Else: cnt <= cnt+1.
  - A disagreement lasting fewer than DEB+1 consecutive cycles leaves o_lvl unchanged and produces no pulse.
- **Edge qualify:** on an update event, o_z <= 1 when one of the following holds; otherwise o_z <= 0.
  - New level 1 and mode is 01 or 11.
  - New level 0 and mode is 10 or 11.
- **Mode:**
  - i_mode is sampled at the update edge. A mode change affects only future updates.
  - Mode 00 suppresses pulses, but the filter still tracks the input, so o_lvl remains valid.
- **Sticky flag:** o_flag <= (o_flag & ~i_clr) | o_z_next.
  - Set wins: a pulse on the same edge as i_clr leaves the flag at 1.
  - i_clr held high clears the flag continuously; only new pulses re-set it.
- **Reset (asynchronous):**
  - Values while reset is high: sync stages = INIT, o_lvl = INIT, cnt = 0, o_z = 0, o_flag = 0, o_any = 0.
  - Asserting reset mid-debounce or mid-pulse aborts the operation with no residual pulse.
  - After release, an input differing from INIT is treated as a genuine edge and is reported after the normal latency.

## Timing
- Latency: an i_a change set up before rising edge E produces an o_lvl change and o_z = 1 in the cycle following edge E+SYNC+DEB. With SYNC = 0 the change appears after edge E+DEB.
- o_z is registered, exactly 1 cycle wide, and never asserts in consecutive cycles on one channel when DEB ≥ 1.
  - With DEB = 0, an input toggling every cycle gives back-to-back pulses in mode 11.
- o_flag rises in the same cycle as o_z. o_any follows o_flag combinationally.
- i_clr takes effect at the next rising edge.
- Channels never interact: simultaneous events on all N channels produce simultaneous pulses.

## Test plan
- **Basic rising edge:** N=8, SYNC=2, DEB=0, mode 01 on channel 0; i_a[0] 0→1 before edge 10 → o_z[0] = 1 only in the cycle after edge 12; o_lvl[0] = 1 from then; o_flag[0] = 1 and o_any = 1.
- **Modes:** channels 0..3 with modes 00/01/10/11; a 1→0→1 square wave with 20-cycle half-period on all four → channel 0 gives no pulses, channel 1 pulses on rises only, channel 2 on falls only, channel 3 on both; all o_lvl track the input.
- **Debounce:** DEB=4; glitches of 1..4 cycles → no change on o_lvl or o_z; a level held for 5 cycles → one pulse at latency SYNC+5 edges.
- **Flag clear collision:** pulse on channel 2 and i_clr[2] on the same edge → o_flag[2] stays 1; i_clr[2] on the following edge → o_flag[2] = 0 and o_any = 0.
- **Reset mid-operation:** assert reset during debounce count 3 of 4 → all outputs 0 immediately; after release with the input held at 1 and INIT=0 → one rising pulse at the normal latency.
- **SYNC=0, back-to-back toggles:** DEB=0, mode 11, i_a toggling every cycle → o_z = 1 every cycle, lagging i_a by one edge.
